i3c_auton_ibi_queue: RTL and testbench



---
 rtl/i3c_auton_ibi_queue_pkg.sv | 15 +
 rtl/i3c_auton_ibi_queue_sync_fifo.sv | 72 +++++++
 rtl/i3c_auton_ibi_queue.sv | 183 ++++++++++++++++++
 tb/tb_i3c_auton_ibi_queue.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i3c_auton_ibi_queue_pkg.sv
// Shared constants for the autonomous I3C IBI/Hot-Join request queue.
// Holds the FSM state encodings and the counter widths used by the top level.
package i3c_auton_ibi_queue_pkg;

    localparam int unsigned IBIQ_STATE_W = 2;
    localparam int unsigned IBIQ_RETRY_W = 4;
    localparam int unsigned IBIQ_BO_W    = 16;
    localparam int unsigned IBIQ_BYTE_W  = 8;

    localparam logic [1:0] IBIQ_IDLE    = 2'd0;
    localparam logic [1:0] IBIQ_IBI     = 2'd1;
    localparam logic [1:0] IBIQ_HJ      = 2'd2;
    localparam logic [1:0] IBIQ_BACKOFF = 2'd3;

endpackage

// File: rtl/i3c_auton_ibi_queue_sync_fifo.sv
// Synchronous FIFO with an occupancy output and a registered write-ready flag.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   wr_en, wr_data      write request and data; accepted only when wr_ready = 1
//   wr_ready            registered "not full"
//   rd_en, rd_data      pop request and current head (valid while level != 0)
//   level               registered occupancy, 0..2**AW
module i3c_sync_fifo #(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    output logic          wr_ready,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [AW:0]   level
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_nx;
    logic          push;
    logic          pop;

    // A full FIFO refuses a write even if a pop happens in the same cycle.
    assign push    = wr_en & wr_ready;
    assign pop     = rd_en & (level != '0);
    assign rd_data = mem[rd_ptr];

    // Next occupancy
    always_comb begin
        level_nx = level;
        if (push && !pop) begin
            level_nx = level + (AW+1)'(1);
        end else if (!push && pop) begin
            level_nx = level - (AW+1)'(1);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, level and ready flag; pointers wrap naturally at 2**AW
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            wr_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level    <= level_nx;
            wr_ready <= (level_nx != (AW+1)'(DEPTH));
        end
    end

endmodule

// File: rtl/i3c_auton_ibi_queue.sv
// System-side IBI/Hot-Join requester for the autonomous I3C slave wrapper.
// Queues event bytes, raises one IBI request at a time, retries NACKed IBIs
// after a backoff, drops an event after RETRY_MAX NACKs, and lets Hot-Join
// pre-empt queued IBIs.
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   ev_valid/ev_byte/ev_ready   event push interface
//   hj_pend                     level Hot-Join request from the system
//   cfg_ibi_ena                 IBI enable (already synchronized)
//   i_ibi_req/i_ibi_byte/i_hj_req   request outputs to the wrapper
//   o_ibi_done/o_ibi_nacked     completion pulses from the wrapper
//   hj_ack/ev_sent/ev_drop      one-cycle status pulses
//   q_level                     FIFO occupancy
module i3c_auton_ibi_queue
    import i3c_auton_ibi_queue_pkg::*;
#(
    parameter int unsigned FIFO_AW     = 2,
    parameter int unsigned RETRY_MAX   = 3,
    parameter logic [15:0] BACKOFF_CYC = 16'd1000,
    parameter int unsigned ENA_HJ      = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ev_valid,
    input  logic [7:0]         ev_byte,
    output logic               ev_ready,
    input  logic               hj_pend,
    input  logic               cfg_ibi_ena,
    output logic               i_ibi_req,
    output logic [7:0]         i_ibi_byte,
    output logic               i_hj_req,
    input  logic               o_ibi_done,
    input  logic               o_ibi_nacked,
    output logic               hj_ack,
    output logic               ev_sent,
    output logic               ev_drop,
    output logic [FIFO_AW:0]   q_level
);

    localparam logic HJ_EN = (ENA_HJ != 0);
    localparam logic [IBIQ_RETRY_W-1:0] RETRY_LIM = IBIQ_RETRY_W'(RETRY_MAX);

    logic [IBIQ_STATE_W-1:0] state, state_nx;
    logic [IBIQ_RETRY_W-1:0] retry, retry_nx;
    logic [IBIQ_BO_W-1:0]    bo_cnt, bo_cnt_nx;
    logic                    ibi_req_nx;
    logic                    hj_req_nx;
    logic [7:0]              ibi_byte_nx;
    logic                    ev_sent_nx;
    logic                    ev_drop_nx;
    logic                    hj_ack_nx;
    logic                    pop;
    logic [7:0]              head;
    logic                    hj_want;

    i3c_sync_fifo #(
        .W  (IBIQ_BYTE_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .wr_en    (ev_valid),
        .wr_data  (ev_byte),
        .wr_ready (ev_ready),
        .rd_en    (pop),
        .rd_data  (head),
        .level    (q_level)
    );

    assign hj_want = HJ_EN & hj_pend;

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IBIQ_IDLE;
            retry      <= '0;
            bo_cnt     <= '0;
            i_ibi_req  <= 1'b0;
            i_ibi_byte <= '0;
            i_hj_req   <= 1'b0;
            ev_sent    <= 1'b0;
            ev_drop    <= 1'b0;
            hj_ack     <= 1'b0;
        end else begin
            state      <= state_nx;
            retry      <= retry_nx;
            bo_cnt     <= bo_cnt_nx;
            i_ibi_req  <= ibi_req_nx;
            i_ibi_byte <= ibi_byte_nx;
            i_hj_req   <= hj_req_nx;
            ev_sent    <= ev_sent_nx;
            ev_drop    <= ev_drop_nx;
            hj_ack     <= hj_ack_nx;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx    = state;
        retry_nx    = retry;
        bo_cnt_nx   = bo_cnt;
        ibi_req_nx  = 1'b0;
        hj_req_nx   = 1'b0;
        ibi_byte_nx = i_ibi_byte;
        ev_sent_nx  = 1'b0;
        ev_drop_nx  = 1'b0;
        hj_ack_nx   = 1'b0;
        pop         = 1'b0;

        case (state)
            IBIQ_IDLE: begin
                if (hj_want) begin
                    state_nx  = IBIQ_HJ;
                    hj_req_nx = 1'b1;
                end else if ((q_level != '0) && cfg_ibi_ena) begin
                    state_nx    = IBIQ_IBI;
                    ibi_req_nx  = 1'b1;
                    ibi_byte_nx = head;
                end
            end

            IBIQ_IBI: begin
                // Wrapper pulses win over a same-cycle disable.
                if (o_ibi_done) begin
                    pop        = 1'b1;
                    ev_sent_nx = 1'b1;
                    retry_nx   = '0;
                    state_nx   = IBIQ_IDLE;
                end else if (o_ibi_nacked) begin
                    if (retry + IBIQ_RETRY_W'(1) == RETRY_LIM) begin
                        pop        = 1'b1;
                        ev_drop_nx = 1'b1;
                        retry_nx   = '0;
                        state_nx   = IBIQ_IDLE;
                    end else begin
                        retry_nx  = retry + IBIQ_RETRY_W'(1);
                        // Counts the NACK cycle itself plus BACKOFF_CYC idle cycles.
                        bo_cnt_nx = BACKOFF_CYC;
                        state_nx  = IBIQ_BACKOFF;
                    end
                end else if (!cfg_ibi_ena) begin
                    state_nx = IBIQ_IDLE;
                end else begin
                    ibi_req_nx = 1'b1;
                end
            end

            IBIQ_BACKOFF: begin
                // Retry count is deliberately kept across a Hot-Join detour.
                if (hj_want) begin
                    state_nx  = IBIQ_HJ;
                    hj_req_nx = 1'b1;
                end else if (bo_cnt == '0) begin
                    if (cfg_ibi_ena) begin
                        state_nx    = IBIQ_IBI;
                        ibi_req_nx  = 1'b1;
                        ibi_byte_nx = head;
                    end else begin
                        state_nx = IBIQ_IDLE;
                    end
                end else begin
                    bo_cnt_nx = bo_cnt - IBIQ_BO_W'(1);
                end
            end

            IBIQ_HJ: begin
                if (o_ibi_done) begin
                    hj_ack_nx = 1'b1;
                    state_nx  = IBIQ_IDLE;
                end else if (!hj_pend) begin
                    state_nx = IBIQ_IDLE;
                end else begin
                    hj_req_nx = 1'b1;
                end
            end

            default: begin
                state_nx = IBIQ_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_i3c_auton_ibi_queue.sv
// Directed self-checking bench for i3c_auton_ibi_queue
// (FIFO_AW=2, RETRY_MAX=3, BACKOFF_CYC=5, ENA_HJ=1).
module tb_i3c_auton_ibi_queue;

    logic       clk;
    logic       rst;
    logic       ev_valid;
    logic [7:0] ev_byte;
    logic       ev_ready;
    logic       hj_pend;
    logic       cfg_ibi_ena;
    logic       i_ibi_req;
    logic [7:0] i_ibi_byte;
    logic       i_hj_req;
    logic       o_ibi_done;
    logic       o_ibi_nacked;
    logic       hj_ack;
    logic       ev_sent;
    logic       ev_drop;
    logic [2:0] q_level;

    int checks   = 0;
    int failures = 0;

    i3c_auton_ibi_queue #(
        .FIFO_AW     (2),
        .RETRY_MAX   (3),
        .BACKOFF_CYC (16'd5),
        .ENA_HJ      (1)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .ev_valid     (ev_valid),
        .ev_byte      (ev_byte),
        .ev_ready     (ev_ready),
        .hj_pend      (hj_pend),
        .cfg_ibi_ena  (cfg_ibi_ena),
        .i_ibi_req    (i_ibi_req),
        .i_ibi_byte   (i_ibi_byte),
        .i_hj_req     (i_hj_req),
        .o_ibi_done   (o_ibi_done),
        .o_ibi_nacked (o_ibi_nacked),
        .hj_ack       (hj_ack),
        .ev_sent      (ev_sent),
        .ev_drop      (ev_drop),
        .q_level      (q_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wrapper must never pulse done and NACK together.
    always @(posedge clk) begin
        if (o_ibi_done && o_ibi_nacked) begin
            failures++;
            $error("FAIL done_nack_overlap observed=1 expected=0");
        end
    end

    // Advance past one active edge; outputs are then settled and inputs may change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(i_ibi_req),  32'h0);
        chk({tag, "_byte"},  32'(i_ibi_byte), 32'h0);
        chk({tag, "_hj"},    32'(i_hj_req),   32'h0);
        chk({tag, "_sent"},  32'(ev_sent),    32'h0);
        chk({tag, "_drop"},  32'(ev_drop),    32'h0);
        chk({tag, "_ack"},   32'(hj_ack),     32'h0);
        chk({tag, "_level"}, 32'(q_level),    32'h0);
        chk({tag, "_ready"}, 32'(ev_ready),   32'h1);
    endtask

    initial begin
        rst = 1'b1; ev_valid = 1'b0; ev_byte = 8'h00; hj_pend = 1'b0;
        cfg_ibi_ena = 1'b0; o_ibi_done = 1'b0; o_ibi_nacked = 1'b0;
        #1;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        cfg_ibi_ena = 1'b1;

        // Single event: push, request one cycle after accept, done
        ev_valid = 1'b1; ev_byte = 8'hA5;
        tick();
        ev_valid = 1'b0;
        chk("t1_level_after_push", 32'(q_level), 32'd1);
        chk("t1_req_not_yet", 32'(i_ibi_req), 32'h0);
        tick();
        chk("t1_req", 32'(i_ibi_req), 32'h1);
        chk("t1_byte", 32'(i_ibi_byte), 32'hA5);
        o_ibi_done = 1'b1;
        tick();
        o_ibi_done = 1'b0;
        chk("t1_req_low", 32'(i_ibi_req), 32'h0);
        chk("t1_sent", 32'(ev_sent), 32'h1);
        chk("t1_level0", 32'(q_level), 32'd0);
        tick();
        chk("t1_sent_one_cycle", 32'(ev_sent), 32'h0);

        // Fill to 4, refused push while full with a same-cycle pop, in-order delivery
        ev_valid = 1'b1; ev_byte = 8'h01; tick();
        ev_byte = 8'h02; tick();
        ev_byte = 8'h03; tick();
        ev_byte = 8'h04; tick();
        chk("t2_full_ready", 32'(ev_ready), 32'h0);
        chk("t2_full_level", 32'(q_level), 32'd4);
        chk("t2_byte01", 32'(i_ibi_byte), 32'h01);
        ev_byte = 8'h05; o_ibi_done = 1'b1;
        tick();
        ev_valid = 1'b0; o_ibi_done = 1'b0;
        chk("t2_no_bypass_level", 32'(q_level), 32'd3);
        chk("t2_sent01", 32'(ev_sent), 32'h1);
        chk("t2_gap1", 32'(i_ibi_req), 32'h0);
        chk("t2_ready_again", 32'(ev_ready), 32'h1);
        tick();
        chk("t2_req02", 32'(i_ibi_req), 32'h1);
        chk("t2_byte02", 32'(i_ibi_byte), 32'h02);
        o_ibi_done = 1'b1; tick(); o_ibi_done = 1'b0;
        chk("t2_gap2", 32'(i_ibi_req), 32'h0);
        tick();
        chk("t2_byte03", 32'(i_ibi_byte), 32'h03);
        chk("t2_req03", 32'(i_ibi_req), 32'h1);
        o_ibi_done = 1'b1; tick(); o_ibi_done = 1'b0;
        chk("t2_gap3", 32'(i_ibi_req), 32'h0);
        tick();
        chk("t2_byte04", 32'(i_ibi_byte), 32'h04);
        o_ibi_done = 1'b1; tick(); o_ibi_done = 1'b0;
        chk("t2_empty", 32'(q_level), 32'd0);
        tick();
        chk("t2_idle_no_req", 32'(i_ibi_req), 32'h0);

        // NACK every attempt: two retries after backoff, then drop
        ev_valid = 1'b1; ev_byte = 8'hB1; tick();
        ev_byte = 8'hB2; tick();
        ev_valid = 1'b0;
        chk("t3_req_b1", 32'(i_ibi_byte), 32'hB1);
        for (int r = 0; r < 2; r++) begin
            o_ibi_nacked = 1'b1; tick(); o_ibi_nacked = 1'b0;
            chk("t3_nack_req_low", 32'(i_ibi_req), 32'h0);
            chk("t3_nack_no_drop", 32'(ev_drop), 32'h0);
            for (int i = 0; i < 5; i++) begin
                tick();
                chk("t3_backoff_low", 32'(i_ibi_req), 32'h0);
            end
            tick();
            chk("t3_rereq", 32'(i_ibi_req), 32'h1);
            chk("t3_rereq_byte", 32'(i_ibi_byte), 32'hB1);
        end
        o_ibi_nacked = 1'b1; tick(); o_ibi_nacked = 1'b0;
        chk("t3_drop", 32'(ev_drop), 32'h1);
        chk("t3_drop_req_low", 32'(i_ibi_req), 32'h0);
        chk("t3_drop_level", 32'(q_level), 32'd1);
        tick();
        chk("t3_drop_one_cycle", 32'(ev_drop), 32'h0);
        chk("t3_next_req", 32'(i_ibi_req), 32'h1);
        chk("t3_next_byte", 32'(i_ibi_byte), 32'hB2);
        o_ibi_done = 1'b1; tick(); o_ibi_done = 1'b0;
        chk("t3_b2_sent", 32'(ev_sent), 32'h1);

        // Hot-Join wins over a queued IBI; NACK in HJ keeps requesting
        cfg_ibi_ena = 1'b0;
        ev_valid = 1'b1; ev_byte = 8'hC3; tick();
        ev_valid = 1'b0; hj_pend = 1'b1; cfg_ibi_ena = 1'b1;
        tick();
        chk("t4_hj_first", 32'(i_hj_req), 32'h1);
        chk("t4_no_ibi", 32'(i_ibi_req), 32'h0);
        o_ibi_nacked = 1'b1; tick(); o_ibi_nacked = 1'b0;
        chk("t4_hj_after_nack", 32'(i_hj_req), 32'h1);
        o_ibi_done = 1'b1; tick(); o_ibi_done = 1'b0; hj_pend = 1'b0;
        chk("t4_hj_ack", 32'(hj_ack), 32'h1);
        chk("t4_hj_low", 32'(i_hj_req), 32'h0);
        tick();
        chk("t4_ack_one_cycle", 32'(hj_ack), 32'h0);
        chk("t4_ibi_after_hj", 32'(i_ibi_req), 32'h1);
        chk("t4_ibi_byte", 32'(i_ibi_byte), 32'hC3);

        // Disable cancels without pop; re-enable requests the same byte
        cfg_ibi_ena = 1'b0; tick();
        chk("t5_cancel_req", 32'(i_ibi_req), 32'h0);
        chk("t5_cancel_level", 32'(q_level), 32'd1);
        tick();
        chk("t5_stay_idle", 32'(i_ibi_req), 32'h0);
        cfg_ibi_ena = 1'b1; tick();
        chk("t5_rereq", 32'(i_ibi_req), 32'h1);
        chk("t5_rereq_byte", 32'(i_ibi_byte), 32'hC3);
        cfg_ibi_ena = 1'b0; o_ibi_done = 1'b1; tick();
        cfg_ibi_ena = 1'b1; o_ibi_done = 1'b0;
        chk("t5_done_beats_cancel", 32'(ev_sent), 32'h1);
        chk("t5_done_pop", 32'(q_level), 32'd0);

        // Hot-Join during backoff keeps the retry count for the pending event
        ev_valid = 1'b1; ev_byte = 8'hF1; tick();
        ev_valid = 1'b0; tick();
        chk("t6_req_f1", 32'(i_ibi_req), 32'h1);
        o_ibi_nacked = 1'b1; tick(); o_ibi_nacked = 1'b0;
        hj_pend = 1'b1; tick();
        chk("t6_hj_in_backoff", 32'(i_hj_req), 32'h1);
        o_ibi_done = 1'b1; tick(); o_ibi_done = 1'b0; hj_pend = 1'b0;
        chk("t6_hj_ack", 32'(hj_ack), 32'h1);
        tick();
        chk("t6_ibi_resume", 32'(i_ibi_req), 32'h1);
        o_ibi_nacked = 1'b1; tick(); o_ibi_nacked = 1'b0;
        chk("t6_second_nack_no_drop", 32'(ev_drop), 32'h0);
        for (int i = 0; i < 5; i++) tick();
        tick();
        chk("t6_third_attempt", 32'(i_ibi_req), 32'h1);
        o_ibi_nacked = 1'b1; tick(); o_ibi_nacked = 1'b0;
        chk("t6_drop_kept_retry", 32'(ev_drop), 32'h1);
        chk("t6_drop_level", 32'(q_level), 32'd0);

        // Reset mid-backoff with three entries queued
        ev_valid = 1'b1; ev_byte = 8'hE1; tick();
        ev_byte = 8'hE2; tick();
        ev_byte = 8'hE3; tick();
        ev_valid = 1'b0;
        o_ibi_nacked = 1'b1; tick(); o_ibi_nacked = 1'b0;
        tick();
        tick();
        chk("t7_pre_reset_level", 32'(q_level), 32'd3);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_reset_outputs("t7_reset");
        o_ibi_done = 1'b1; tick(); o_ibi_done = 1'b0;
        chk("t7_stray_done_sent", 32'(ev_sent), 32'h0);
        chk("t7_stray_done_req", 32'(i_ibi_req), 32'h0);
        tick();
        chk("t7_idle_empty", 32'(i_ibi_req), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
